// File: rtl/alu_sched_pkg.sv
// Shared definitions for the two-client round-robin ALU scheduler: opcode codes,
// FSM state encoding and the opcode legality check.
package alu_sched_pkg;

  localparam logic [3:0] OP_ADD = 4'b0000;
  localparam logic [3:0] OP_SUB = 4'b0001;
  localparam logic [3:0] OP_NEG = 4'b0011;
  localparam logic [3:0] OP_AND = 4'b1000;
  localparam logic [3:0] OP_XOR = 4'b1001;
  localparam logic [3:0] OP_OR  = 4'b1010;
  localparam logic [3:0] OP_NOT = 4'b1011;
  localparam logic [3:0] OP_ROR = 4'b1100;
  localparam logic [3:0] OP_ROL = 4'b1101;
  localparam logic [3:0] OP_SHR = 4'b1110;
  localparam logic [3:0] OP_SHL = 4'b1111;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_e;

  function automatic logic is_legal_op(input logic [3:0] op);
    case (op)
      OP_ADD, OP_SUB, OP_NEG, OP_AND, OP_XOR, OP_OR,
      OP_NOT, OP_ROR, OP_ROL, OP_SHR, OP_SHL: return 1'b1;
      default:                                return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/rr_arbiter_2.sv
// Two-way round-robin arbiter: one-hot grant while enabled; the tie-break pointer
// moves to the other requester whenever a grant is given.
module rr_arbiter_2 (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [1:0] req,
  output logic [1:0] gnt
);

  logic ptr_q;  // requester that wins the next tie

  // NOTE: default every always_comb output first so no path leaves it unassigned (latch).
  always_comb begin
    gnt = 2'b00;
    if (en) begin
      case (req)
        2'b01:   gnt = 2'b01;
        2'b10:   gnt = 2'b10;
        2'b11:   gnt = ptr_q ? 2'b10 : 2'b01;
        default: gnt = 2'b00;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q <= 1'b0;
    end else if (|gnt) begin
      ptr_q <= gnt[0];
    end
  end

endmodule

// File: rtl/alu_rr_sched.sv
// Round-robin scheduler sharing one registered ALU between two requesters.
// Optional opcode screening is enabled by defining ALU_SCHED_OPCODE_CHECK_EN.
module alu_rr_sched
  import alu_sched_pkg::*;
#(
  parameter int WIDTH   = 8,
  parameter int ALU_LAT = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [1:0]           req_valid,
  output logic [1:0]           req_ready,
  input  logic [7:0]           req_op,
  input  logic [2*WIDTH-1:0]   req_a,
  input  logic [2*WIDTH-1:0]   req_b,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic                 rsp_id,
  output logic [WIDTH-1:0]     rsp_f,
  output logic                 rsp_z,
  output logic                 rsp_c,
  output logic                 rsp_ovf,
  output logic                 rsp_err,
  output logic [WIDTH-1:0]     alu_A,
  output logic [WIDTH-1:0]     alu_B,
  output logic [3:0]           alu_sel,
  input  logic [WIDTH-1:0]     alu_F,
  input  logic                 alu_z,
  input  logic                 alu_c_out,
  input  logic                 alu_over_flow
);

  localparam int CW = (ALU_LAT > 0) ? $clog2(ALU_LAT + 1) : 1;

  state_e           state_q, state_d;
  logic [1:0]       gnt;
  logic             accept, gnt_id, op_legal, err_q;
  logic [3:0]       sel_op;
  logic [WIDTH-1:0] sel_a, sel_b;
  logic [CW-1:0]    cnt_q;

  rr_arbiter_2 u_arb (
    .clk (clk),
    .rst (rst),
    .en  (state_q == S_IDLE),
    .req (req_valid),
    .gnt (gnt)
  );

  assign req_ready = gnt;
  assign accept    = |gnt;
  assign gnt_id    = gnt[1];
  assign sel_op    = gnt_id ? req_op[7:4] : req_op[3:0];
  assign sel_a     = gnt_id ? req_a[2*WIDTH-1:WIDTH] : req_a[WIDTH-1:0];
  assign sel_b     = gnt_id ? req_b[2*WIDTH-1:WIDTH] : req_b[WIDTH-1:0];
  assign rsp_valid = (state_q == S_RESP);
  assign rsp_err   = err_q;

`ifdef ALU_SCHED_OPCODE_CHECK_EN
  assign op_legal = is_legal_op(sel_op);
`else
  assign op_legal = 1'b1;
`endif

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (accept) state_d = op_legal ? S_WAIT : S_RESP;
      S_WAIT:  if (cnt_q == '0) state_d = S_RESP;
      S_RESP:  if (rsp_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Illegal ops never touch the ALU; their response payload is forced to zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      alu_A   <= '0;
      alu_B   <= '0;
      alu_sel <= '0;
      cnt_q   <= '0;
      rsp_id  <= 1'b0;
      rsp_f   <= '0;
      rsp_z   <= 1'b0;
      rsp_c   <= 1'b0;
      rsp_ovf <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (accept) begin
            rsp_id <= gnt_id;
            err_q  <= ~op_legal;
            if (op_legal) begin
              alu_A   <= sel_a;
              alu_B   <= sel_b;
              alu_sel <= sel_op;
              cnt_q   <= CW'(ALU_LAT);
            end else begin
              rsp_f   <= '0;
              rsp_z   <= 1'b0;
              rsp_c   <= 1'b0;
              rsp_ovf <= 1'b0;
            end
          end
        end
        S_WAIT: begin
          if (cnt_q == '0) begin
            rsp_f   <= alu_F;
            rsp_z   <= alu_z;
            rsp_c   <= alu_c_out;
            rsp_ovf <= alu_over_flow;
          end else begin
            cnt_q <= cnt_q - CW'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_rr_sched.sv
// Self-checking bench for alu_rr_sched: registered ALU model, requester agents,
// a transaction-level scoreboard checked every cycle, and directed literal checks.
module tb_alu_rr_sched;

  localparam int WIDTH   = 8;
  localparam int ALU_LAT = 1;

  typedef struct packed {
    logic [7:0] f;
    logic       z;
    logic       c;
    logic       v;
  } alu_res_t;

  typedef struct {
    logic [3:0] op;
    logic [7:0] a;
    logic [7:0] b;
  } op_t;

  typedef struct {
    logic       id;
    logic [7:0] f;
    logic       z, c, v, err;
    int         lat;
  } rsp_t;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [1:0]   req_valid = '0;
  logic [1:0]   req_ready;
  logic [7:0]   req_op = '0;
  logic [15:0]  req_a = '0;
  logic [15:0]  req_b = '0;
  logic         rsp_valid;
  logic         rsp_ready = 1'b1;
  logic         rsp_id;
  logic [7:0]   rsp_f;
  logic         rsp_z, rsp_c, rsp_ovf, rsp_err;
  logic [7:0]   alu_A, alu_B;
  logic [3:0]   alu_sel;
  logic [7:0]   alu_F = '0;
  logic         alu_z = 1'b0, alu_c_out = 1'b0, alu_over_flow = 1'b0;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int n_hs     = 0;

  op_t  q0[$];
  op_t  q1[$];
  rsp_t rsp_log[$];

  alu_rr_sched #(.WIDTH(WIDTH), .ALU_LAT(ALU_LAT)) dut (
    .clk           (clk),
    .rst           (rst),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_op        (req_op),
    .req_a         (req_a),
    .req_b         (req_b),
    .rsp_valid     (rsp_valid),
    .rsp_ready     (rsp_ready),
    .rsp_id        (rsp_id),
    .rsp_f         (rsp_f),
    .rsp_z         (rsp_z),
    .rsp_c         (rsp_c),
    .rsp_ovf       (rsp_ovf),
    .rsp_err       (rsp_err),
    .alu_A         (alu_A),
    .alu_B         (alu_B),
    .alu_sel       (alu_sel),
    .alu_F         (alu_F),
    .alu_z         (alu_z),
    .alu_c_out     (alu_c_out),
    .alu_over_flow (alu_over_flow)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic alu_res_t alu_fn(input logic [7:0] a, input logic [7:0] b, input logic [3:0] op);
    alu_res_t   r;
    logic [8:0] s;
    r = '0;
    s = '0;
    case (op)
      4'b0000: begin s = {1'b0, a} + {1'b0, b};        r.f = s[7:0]; r.c = s[8];
                     r.v = (a[7] == b[7]) && (r.f[7] != a[7]); end
      4'b0001: begin s = {1'b0, a} + {1'b0, ~b} + 9'd1; r.f = s[7:0]; r.c = s[8];
                     r.v = (a[7] != b[7]) && (r.f[7] != a[7]); end
      4'b0011: begin r.f = 8'd0 - a; r.c = (a != 8'd0); r.v = (a == 8'h80); end
      4'b1000: r.f = a & b;
      4'b1001: r.f = a ^ b;
      4'b1010: r.f = a | b;
      4'b1011: r.f = ~a;
      4'b1100: begin r.f = {a[0], a[7:1]}; r.c = a[0]; end
      4'b1101: begin r.f = {a[6:0], a[7]}; r.c = a[7]; end
      4'b1110: begin r.f = a >> 1; r.c = a[0]; end
      4'b1111: begin r.f = a << 1; r.c = a[7]; end
      default: ;
    endcase
    r.z = (r.f == 8'd0);
    return r;
  endfunction

  function automatic logic op_ok(input logic [3:0] op);
`ifdef ALU_SCHED_OPCODE_CHECK_EN
    return !(op inside {4'd2, 4'd4, 4'd5, 4'd6, 4'd7});
`else
    return 1'b1;
`endif
  endfunction

  // Registered ALU, one edge of latency.
  always @(posedge clk) {alu_F, alu_z, alu_c_out, alu_over_flow} <= alu_fn(alu_A, alu_B, alu_sel);

  // Requester agents: hold valid/payload from the queue front until handshake.
  logic [1:0] hs;
  always begin
    @(negedge clk);
    hs = rst ? 2'b00 : (req_valid & req_ready);
    @(posedge clk);
    #1;
    if (hs[0] && q0.size() > 0) void'(q0.pop_front());
    if (hs[1] && q1.size() > 0) void'(q1.pop_front());
    req_valid[0] = (q0.size() != 0);
    req_valid[1] = (q1.size() != 0);
    if (q0.size() != 0) begin
      req_op[3:0] = q0[0].op; req_a[7:0] = q0[0].a; req_b[7:0] = q0[0].b;
    end
    if (q1.size() != 0) begin
      req_op[7:4] = q1[0].op; req_a[15:8] = q1[0].a; req_b[15:8] = q1[0].b;
    end
  end

  // Scoreboard: at most one op in flight; last_id drives the tie-break rule.
  logic       m_busy = 1'b0;
  logic       m_last = 1'b1;
  logic       just_rst = 1'b0;
  int         m_acc_cyc = 0;
  int         m_lat = 0;
  rsp_t       m_exp;
  logic [7:0] exp_a = '0, exp_b = '0;
  logic [3:0] exp_sel = '0;
  logic [1:0] exp_rdy;
  logic       exp_valid;
  logic       prev_v = 1'b0;
  int         dut_acc = 0;
  logic       gid;
  alu_res_t   r;

  always @(negedge clk) begin
    if (rst) begin
      m_busy = 1'b0; m_last = 1'b1; just_rst = 1'b1; prev_v = 1'b0;
      exp_a = '0; exp_b = '0; exp_sel = '0;
    end else begin
      if (|(req_valid & req_ready)) dut_acc = cyc;
      if (rsp_valid && !prev_v)
        rsp_log.push_back('{rsp_id, rsp_f, rsp_z, rsp_c, rsp_ovf, rsp_err, cyc - dut_acc});
      prev_v = rsp_valid;
      if (rsp_valid && rsp_ready) n_hs++;

      exp_rdy = 2'b00;
      if (!m_busy) begin
        if (req_valid == 2'b01)      exp_rdy = 2'b01;
        else if (req_valid == 2'b10) exp_rdy = 2'b10;
        else if (req_valid == 2'b11) exp_rdy = m_last ? 2'b01 : 2'b10;
      end
      check("req_ready", req_ready, exp_rdy);
      check("alu_A", alu_A, exp_a);
      check("alu_B", alu_B, exp_b);
      check("alu_sel", alu_sel, exp_sel);
      if (just_rst) begin
        check("rst_rsp", {rsp_id, rsp_f, rsp_z, rsp_c, rsp_ovf, rsp_err}, 0);
        just_rst = 1'b0;
      end
      exp_valid = m_busy && ((cyc - m_acc_cyc) >= m_lat);
      check("rsp_valid", rsp_valid, exp_valid);
      if (exp_valid) begin
        check("rsp_id", rsp_id, m_exp.id);
        check("rsp_f", rsp_f, m_exp.f);
        check("rsp_flags", {rsp_z, rsp_c, rsp_ovf}, {m_exp.z, m_exp.c, m_exp.v});
        check("rsp_err", rsp_err, m_exp.err);
        if (rsp_ready) m_busy = 1'b0;
      end else if (|exp_rdy) begin
        gid = exp_rdy[1];
        m_busy = 1'b1; m_last = gid; m_acc_cyc = cyc;
        if (op_ok(req_op[gid*4 +: 4])) begin
          exp_a   = req_a[gid*8 +: 8];
          exp_b   = req_b[gid*8 +: 8];
          exp_sel = req_op[gid*4 +: 4];
          r       = alu_fn(exp_a, exp_b, exp_sel);
          m_exp   = '{gid, r.f, r.z, r.c, r.v, 1'b0, 0};
          m_lat   = ALU_LAT + 2;
        end else begin
          m_exp = '{gid, 8'd0, 1'b0, 1'b0, 1'b0, 1'b1, 0};
          m_lat = 1;
        end
      end
    end
  end

  task automatic wait_idle();
    int i;
    for (i = 0; i < 300; i++) begin
      @(posedge clk); #3;
      if (q0.size() == 0 && q1.size() == 0 && !m_busy && req_valid == 2'b00) break;
    end
    if (i == 300) begin
      n_checks++; n_fail++;
      $display("FAIL wait_idle: still busy after 300 cycles, expected idle");
    end
    repeat (2) @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    @(posedge clk); #2 rst = 1'b1;
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int base;
    int i;
    repeat (3) @(posedge clk);
    #2 rst = 1'b0;

    // Single requester ADD
    q0.push_back('{4'b0000, 8'd3, 8'd2});
    wait_idle();
    check("t1_id", rsp_log[0].id, 0);
    check("t1_f", rsp_log[0].f, 8'd5);
    check("t1_flags", {rsp_log[0].z, rsp_log[0].c, rsp_log[0].v}, 3'b000);
    check("t1_lat", rsp_log[0].lat, 3);

    // Tie after reset: r0 first, zero flag
    do_reset();
    q0.push_back('{4'b0001, 8'd3, 8'd3});
    q1.push_back('{4'b1000, 8'd3, 8'd2});
    wait_idle();
    check("t2_first_id", rsp_log[1].id, 0);
    check("t2_first_f", rsp_log[1].f, 8'd0);
    check("t2_first_z", rsp_log[1].z, 1);
    check("t2_second_id", rsp_log[2].id, 1);
    check("t2_second_f", rsp_log[2].f, 8'd2);

    // Continuous contention
    for (i = 0; i < 2; i++) begin
      q0.push_back('{4'b0000, 8'd127, 8'd1});
      q1.push_back('{4'b1001, 8'd3, 8'd2});
    end
    wait_idle();
    check("t3_ids", {rsp_log[3].id, rsp_log[4].id, rsp_log[5].id, rsp_log[6].id}, 4'b0101);
    check("t3_r0_f", rsp_log[3].f, 8'h80);
    check("t3_r0_ovf", rsp_log[5].v, 1);
    check("t3_r1_f", rsp_log[4].f, 8'h01);
    check("t3_r1_ovf", rsp_log[6].v, 0);

    // Backpressure in RESP
    rsp_ready = 1'b0;
    base = n_hs;
    q1.push_back('{4'b1010, 8'h0F, 8'hF0});
    for (i = 0; i < 20 && !rsp_valid; i++) begin
      @(posedge clk); #3;
    end
    check("bp_valid_seen", rsp_valid, 1);
    repeat (5) @(posedge clk);
    #2 rsp_ready = 1'b1;
    wait_idle();
    check("bp_one_handshake", n_hs - base, 1);
    check("bp_f", rsp_log[7].f, 8'hFF);
    check("bp_id", rsp_log[7].id, 1);

    // Lone requester served back-to-back
    q0.push_back('{4'b1100, 8'h01, 8'h00});
    q0.push_back('{4'b1111, 8'h81, 8'h00});
    wait_idle();
    check("lone_ror", {rsp_log[8].id, rsp_log[8].f, rsp_log[8].c}, {1'b0, 8'h80, 1'b1});
    check("lone_shl", {rsp_log[9].id, rsp_log[9].f, rsp_log[9].c}, {1'b0, 8'h02, 1'b1});

    // Reset one cycle after accept abandons the op
    q0.push_back('{4'b0000, 8'd1, 8'd1});
    for (i = 0; i < 20 && !m_busy; i++) begin
      @(posedge clk); #3;
    end
    rst = 1'b1;
    @(posedge clk); #2 rst = 1'b0;
    repeat (6) @(posedge clk);
    #2;
    check("rst_no_rsp", rsp_log.size(), 10);
    q0.push_back('{4'b0000, 8'd1, 8'd1});
    q1.push_back('{4'b0011, 8'd1, 8'd0});
    wait_idle();
    check("rst_tie_first", {rsp_log[10].id, rsp_log[10].f}, {1'b0, 8'd2});
    check("rst_tie_second", {rsp_log[11].id, rsp_log[11].f, rsp_log[11].c}, {1'b1, 8'hFF, 1'b1});

    // Opcode 0101 from r1
    q1.push_back('{4'b0101, 8'd5, 8'd6});
    wait_idle();
    check("op5_id", rsp_log[12].id, 1);
`ifdef ALU_SCHED_OPCODE_CHECK_EN
    check("op5_err", rsp_log[12].err, 1);
    check("op5_f", rsp_log[12].f, 8'd0);
    check("op5_lat", rsp_log[12].lat, 1);
    check("op5_sel_kept", alu_sel, 4'b0011);
`else
    check("op5_err", rsp_log[12].err, 0);
    check("op5_lat", rsp_log[12].lat, 3);
    check("op5_sel_fwd", alu_sel, 4'b0101);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
